// File: rtl/debruijn_pkg.sv
// Shared constants for the de Bruijn sequence generator: legal width range and
// the default Fibonacci feedback tap table indexed by state width.
package debruijn_pkg;

  localparam int WIDTH_MIN = 3;
  localparam int WIDTH_MAX = 8;

  typedef logic [WIDTH_MAX-1:0] tap_t;

  // Every default mask has its MSB set, which is what makes the step invertible.
  function automatic tap_t default_tap(input int width);
    case (width)
      3:       return 8'b0000_0110;
      4:       return 8'b0000_1100;
      5:       return 8'b0001_0100;
      6:       return 8'b0011_0000;
      7:       return 8'b0110_0000;
      8:       return 8'b1011_1000;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/debruijn_step.sv
// Combinational next-state logic for the de Bruijn generator.
// Reverse stepping is built only when DEBRUIJN_REVERSE_EN is defined.
module debruijn_step
  import debruijn_pkg::*;
#(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] TAP_MASK = WIDTH'(default_tap(WIDTH))
) (
  input  logic [WIDTH-1:0] cur,
  input  logic             dir,
  output logic [WIDTH-1:0] nxt
);

  logic             fwd_bit;
  logic [WIDTH-1:0] fwd_state;

  // The all-zero-low-bits correction splices 0...0 into the maximal LFSR cycle.
  assign fwd_bit   = (^(cur & TAP_MASK)) ^ (cur[WIDTH-2:0] == '0);
  assign fwd_state = {cur[WIDTH-2:0], fwd_bit};

`ifdef DEBRUIJN_REVERSE_EN
  logic             rev_bit;
  logic [WIDTH-1:0] rev_state;

  // Solve the forward equation for the bit that was shifted out of the MSB.
  assign rev_bit   = cur[0] ^ (^(cur[WIDTH-1:1] & TAP_MASK[WIDTH-2:0]))
                   ^ (cur[WIDTH-1:1] == '0);
  assign rev_state = {rev_bit, cur[WIDTH-1:1]};
  assign nxt       = dir ? rev_state : fwd_state;
`else
  logic unused_dir;
  assign unused_dir = dir;
  assign nxt        = fwd_state;
`endif

endmodule

// File: rtl/debruijn_gen.sv
// De Bruijn sequence generator: state, step counter and period-wrap pulse.
// Define DEBRUIJN_REVERSE_EN to make the dir port step backwards.
module debruijn_gen
  import debruijn_pkg::*;
#(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] TAP_MASK = WIDTH'(default_tap(WIDTH))
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] seed,
  input  logic             sel,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("debruijn_gen: WIDTH %0d outside legal range %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
  end

  if (TAP_MASK[WIDTH-1] !== 1'b1) begin : g_tap_check
    $error("debruijn_gen: TAP_MASK MSB must be set for an invertible step");
  end

  logic [WIDTH-1:0] state_next;
  logic [WIDTH-1:0] count_next;

  debruijn_step #(
    .WIDTH    (WIDTH),
    .TAP_MASK (TAP_MASK)
  ) u_step (
    .cur (state),
    .dir (dir),
    .nxt (state_next)
  );

`ifdef DEBRUIJN_REVERSE_EN
  assign count_next = dir ? count - WIDTH'(1) : count + WIDTH'(1);
`else
  assign count_next = count + WIDTH'(1);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WIDTH'(1);
      count <= '0;
      wrap  <= 1'b0;
    end else if (!sel) begin
      state <= seed;
      count <= '0;
      wrap  <= 1'b0;
    end else if (en) begin
      state <= state_next;
      count <= count_next;
      wrap  <= (count_next == '0);
    end else begin
      wrap  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_debruijn_gen.sv
// Self-checking bench for debruijn_gen: WIDTH=4 directed vectors against a
// behavioural model, plus full-period sweeps for every WIDTH 3..8.
module tb_debruijn_gen;

  localparam int W   = 4;
  localparam int MOD = 1 << W;
`ifdef DEBRUIJN_REVERSE_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, sel, en, dir;
  logic [W-1:0] seed, state, count;
  logic         wrap;

  int compared   = 0;
  int mismatched = 0;
  bit sweep_go   = 0;

  always #5 clk = ~clk;

  debruijn_gen #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .seed  (seed),
    .sel   (sel),
    .en    (en),
    .dir   (dir),
    .state (state),
    .count (count),
    .wrap  (wrap)
  );

  // ---------------- behavioural model ----------------
  function automatic int tap(input int w);
    case (w)
      3: return 'b110;
      4: return 'b1100;
      5: return 'b10100;
      6: return 'b110000;
      7: return 'b1100000;
      default: return 'b10111000;
    endcase
  endfunction

  function automatic int fwd(input int s, input int w);
    int ones = 0;
    int f;
    for (int i = 0; i < w; i++) if ((((s & tap(w)) >> i) & 1) == 1) ones++;
    f = (ones % 2) ^ (((s % (1 << (w - 1))) == 0) ? 1 : 0);
    return (s * 2 + f) % (1 << w);
  endfunction

  // Predecessor found by search: the unique p with fwd(p) == s.
  function automatic int rev(input int s, input int w);
    for (int p = 0; p < (1 << w); p++) if (fwd(p, w) == s) return p;
    return -1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  int m_state = 0, m_count = 0, m_nc;
  bit m_wrap  = 0, m_valid = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_state <= 1; m_count <= 0; m_wrap <= 0; m_valid <= 1;
    end else if (!sel) begin
      m_state <= int'(seed); m_count <= 0; m_wrap <= 0;
    end else if (en) begin
      if (REV && dir) begin
        m_state <= rev(m_state, W);
        m_nc = (m_count + MOD - 1) % MOD;
      end else begin
        m_state <= fwd(m_state, W);
        m_nc = (m_count + 1) % MOD;
      end
      m_count <= m_nc;
      m_wrap  <= (m_nc == 0);
    end else begin
      m_wrap <= 0;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc_state", int'(state), m_state);
      check("cyc_count", int'(count), m_count);
      check("cyc_wrap", int'(wrap), int'(m_wrap));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic r, input logic s, input logic e, input logic d,
                       input logic [W-1:0] sd);
    rst = r; sel = s; en = e; dir = d; seed = sd;
    @(posedge clk); #1;
    $display("txn rst=%0b sel=%0b en=%0b dir=%0b seed=%b -> state=%b count=%0d wrap=%0b",
             r, s, e, d, sd, state, count, wrap);
  endtask

  task automatic expect3(input string name, input int st, input int ct, input int wp);
    check({name, "_state"}, int'(state), st);
    check({name, "_count"}, int'(count), ct);
    check({name, "_wrap"}, int'(wrap), wp);
  endtask

  int seq [16] = '{4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010, 4'b0101,
                   4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0001};

  initial begin
    rst = 1; sel = 1; en = 0; dir = 0; seed = '0;

    drive(1, 1, 1, 0, 4'b0110);
    expect3("reset", 1, 0, 0);

    drive(0, 0, 0, 0, 4'b0001);
    expect3("load1", 1, 0, 0);
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 1, 0, 4'b0000);
      expect3($sformatf("seq%0d", i), seq[i], (i + 1) % 16, (i == 15) ? 1 : 0);
    end

    drive(0, 1, 0, 1, 4'b0000);
    expect3("hold", 1, 0, 0);

`ifdef DEBRUIJN_REVERSE_EN
    drive(0, 1, 1, 1, 4'b0000);
    expect3("rev1", 0, 15, 0);
    drive(0, 1, 1, 1, 4'b0000);
    expect3("rev2", 8, 14, 0);
    drive(0, 0, 0, 0, 4'b0001);
    drive(0, 1, 1, 0, 4'b0000);
    expect3("fwd_then", 2, 1, 0);
    drive(0, 1, 1, 1, 4'b0000);
    expect3("rev_wrap", 1, 0, 1);
`else
    drive(0, 1, 1, 1, 4'b0000);
    expect3("dir_ignored", 2, 1, 0);
`endif

    // Direction flips between consecutive steps, with occasional idle cycles.
    for (int i = 0; i < 30; i++) drive(0, 1, (i % 5) != 0, ((i / 3) % 2) == 1, 4'b0000);
    for (int i = 0; i < 40; i++) drive(0, 1, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'b0000);

    drive(0, 0, 0, 0, 4'b0001);
    for (int i = 0; i < 6; i++) drive(0, 1, 1, 0, 4'b0000);
    expect3("step6", 4'b1101, 6, 0);
    drive(1, 1, 1, 0, 4'b0000);
    expect3("rst_mid", 1, 0, 0);

    drive(0, 0, 1, 1, 4'b1010);
    expect3("load_en", 4'b1010, 0, 0);

    drive(0, 0, 0, 0, 4'b0000);
    expect3("load_zero", 0, 0, 0);
    drive(0, 1, 1, 0, 4'b0000);
    expect3("zero_step", 1, 1, 0);

    drive(0, 1, 0, 0, 4'b0000);
    sweep_go = 1;
    begin
      int t = 0;
      while (t < 600 && !(g_sw[3].done && g_sw[4].done && g_sw[5].done &&
                         g_sw[6].done && g_sw[7].done && g_sw[8].done)) begin
        @(posedge clk);
        t++;
      end
      check("sweep_done", int'(g_sw[3].done && g_sw[4].done && g_sw[5].done &&
                               g_sw[6].done && g_sw[7].done && g_sw[8].done), 1);
    end

    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // ---------------- full-period sweep for every legal width ----------------
  for (genvar gi = 3; gi <= 8; gi++) begin : g_sw
    logic          s_rst, s_sel, s_en, s_wrap;
    logic [gi-1:0] s_seed, s_state, s_count;
    bit            done = 0;

    debruijn_gen #(.WIDTH(gi)) u_dut (
      .clk   (clk),
      .rst   (s_rst),
      .seed  (s_seed),
      .sel   (s_sel),
      .en    (s_en),
      .dir   (1'b0),
      .state (s_state),
      .count (s_count),
      .wrap  (s_wrap)
    );

    initial begin
      bit seen [256];
      int distinct = 0;
      int prev = 0;
      s_rst = 1; s_sel = 1; s_en = 0; s_seed = '0;
      wait (sweep_go);
      @(posedge clk); #1;
      s_rst = 0; s_sel = 0;
      @(posedge clk); #1;
      check($sformatf("sweep%0d_load", gi), int'(s_state), 0);
      s_sel = 1; s_en = 1;
      for (int i = 0; i < (1 << gi); i++) begin
        @(posedge clk); #1;
        check($sformatf("sweep%0d_step", gi), int'(s_state), fwd(prev, gi));
        if (!seen[int'(s_state)]) distinct++;
        seen[int'(s_state)] = 1;
        prev = int'(s_state);
      end
      s_en = 0;
      check($sformatf("sweep%0d_distinct", gi), distinct, 1 << gi);
      check($sformatf("sweep%0d_final", gi), int'(s_state), 0);
      check($sformatf("sweep%0d_count", gi), int'(s_count), 0);
      check($sformatf("sweep%0d_wrap", gi), int'(s_wrap), 1);
      $display("txn sweep width=%0d steps=%0d distinct=%0d final=%0d", gi, 1 << gi, distinct, s_state);
      done = 1;
    end
  end

endmodule

// File: doc/debruijn_gen.md
DEBRUIJN_GEN -- requirements
Module: debruijn_gen

Interface
REQ-001 Parameter: WIDTH, default 4, state width in bits; legal range 3..8.
REQ-002 Parameter: TAP_MASK, default debruijn_pkg tap entry for WIDTH, Fibonacci feedback mask.
REQ-003 Port: clk  input  1  single clock, all logic rising-edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: seed  input  WIDTH  value loaded into state when sel=0.
REQ-006 Port: sel  input  1  0 = load seed, 1 = run.
REQ-007 Port: en  input  1  step enable while running.
REQ-008 Port: dir  input  1  0 = forward step, 1 = reverse step.
REQ-009 Port: state  output  WIDTH  current de Bruijn state, registered.
REQ-010 Port: count  output  WIDTH  steps since last load, modulo 2^WIDTH, registered.
REQ-011 Port: wrap  output  1  one-cycle pulse, registered, on period completion.

Function
REQ-012 Forward step SHALL be next = {state[WIDTH-2:0], f}, where f = parity(state & TAP_MASK) XOR (state[WIDTH-2:0] == 0).
REQ-013 Forward stepping SHALL visit all 2^WIDTH states, including all-zero, with period exactly 2^WIDTH.
REQ-014 Reverse step SHALL be the exact inverse of the forward step: prev = {b, state[WIDTH-1:1]}, with b chosen so that forward(prev) == state.
REQ-015 Priority per edge SHALL be rst, then sel=0 load, then sel=1&en=1 step, else hold.
REQ-016 Load SHALL set state<=seed, count<=0, wrap<=0, regardless of en/dir.
REQ-017 A step SHALL update state one cycle after the edge on which en=1 is sampled; latency 1, throughput 1 step/cycle.
REQ-018 A forward step SHALL increment count, and a reverse step SHALL decrement it; both modulo 2^WIDTH.
REQ-019 wrap SHALL be 1 in the cycle after a step whose new count equals 0; this covers forward 2^WIDTH-1->0 and reverse 1->0.
REQ-020 wrap SHALL be 0 in every other cycle.
REQ-021 A dir change between consecutive steps SHALL take effect on the next step, without bubble.
REQ-022 en=0 with sel=1 SHALL hold state and count and drive wrap=0.
REQ-023 Any seed value, including all-zero, SHALL be a legal load.

Reset
REQ-024 rst=1 SHALL set state<={WIDTH{0}} with bit0=1, count<=0, wrap<=0 at the next rising edge.
REQ-025 rst SHALL override sel and en in the same cycle, including mid-sequence.

Configuration
REQ-026 Macro DEBRUIJN_REVERSE_EN defined: dir port SHALL be functional per REQ-014/REQ-018.
REQ-027 Macro DEBRUIJN_REVERSE_EN undefined: dir port SHALL remain present but be ignored, only forward stepping SHALL occur, and no reverse logic SHALL be synthesised.

Structure
REQ-028 Package debruijn_pkg SHALL hold WIDTH_MIN=3, WIDTH_MAX=8 and the default tap table: 3:110, 4:1100, 5:10100, 6:110000, 7:1100000, 8:10111000.
REQ-029 Combinational forward/reverse next-state logic SHALL live in sub-module debruijn_step, instantiated once.
REQ-030 Registers, count and wrap SHALL live in debruijn_gen.
REQ-031 WIDTH outside 3..8 SHALL cause an elaboration error.

Verification
REQ-032 WIDTH=4, rst 1 cycle -> state=0001, count=0, wrap=0.
REQ-033 WIDTH=4, seed=0001, sel=0 one cycle then sel=1,en=1,dir=0 -> state sequence 0010,0100,1001,0011,0110,1101,...,1000,0000,0001.
REQ-034 Continuing REQ-033, the 16th step returns state to 0001 -> wrap=1 for exactly that cycle, count=0.
REQ-035 Reverse, with DEBRUIJN_REVERSE_EN defined: from state=0001,count=0, dir=1 -> state 0000 (count 15), then 1000 (count 14).
REQ-036 Reverse after 1 forward step: dir=1 -> state 0001, count 0, wrap=1.
REQ-037 Reset mid-run: rst=1 at step 7 with en=1 -> state 0001, count 0 next cycle.
REQ-038 Sweep each WIDTH 3..8: 2^WIDTH steps visit every state exactly once.
REQ-039 Load with en=1: seed=1010, sel=0 -> state 1010, count 0, no step.
